// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_stage
//
// MEM stage plus the MEM/WB pipeline latch.
//   * Drives the data memory from the EX/MEM register outputs (load/store).
//   * Resolves the branch/jump prediction made at fetch and, on a mispredict,
//     raises a same-cycle fetch redirect (which also flushes upstream stages).
//   * Latches the writeback value, destination and write enable for WB.
//   * Sequences processor halt through a RUN -> DRAIN -> HALTED FSM.
//
// Optional feature (compile-time macro MEM_WB_RETIRE_COUNT_EN):
//   defined   : retired_o counts every enabled, valid cycle (wraps at 2^32).
//   undefined : retired_o is tied to zero and no counter flops are built.
//
// Handshake / stall semantics:
//   latchn=1 is a stall. While it is high the MEM/WB latch, the halt FSM and
//   the retire counter hold their values, no memory write is issued
//   (D_MEM_WEN=1) and no redirect is raised. Reads may still be selected.
//   An instruction "happens" only on a posedge with latchn=0 and valid=1,
//   where valid = ~flush_i & (state != HALTED).
//
// Ports:
//   CLK, RSTn            clock (posedge) and synchronous active-low reset
//   latchn               stall (1 = hold)
//   aluResult_i          ALU result / effective address
//   baluResult_i         branch condition (1 = taken)
//   target_i             branch/jump target
//   rd_i                 destination register
//   is*type_i            instruction type flags (0 when flushed)
//   probablyHalt_i       halt candidate (already flush-gated)
//   opcode_i             opcode, 7'b0000011 = load
//   memWriteValue_i      store data
//   pc_i                 instruction pc
//   bpr_i                fetch prediction (1 = predicted taken)
//   flush_i              bubble in MEM
//   D_MEM_*              data memory interface (CSN/WEN active-low)
//   redirect_o           fetch redirect request (combinational)
//   redirectPc_o         redirect address (0 when no redirect)
//   wbData_o/wbRd_o/wbWe_o  MEM/WB latch outputs
//   halt_o               1 while HALTED
//   retired_o            retired instruction count
//   dbg_state            current halt FSM state (debug visibility)
// ---------------------------------------------------------------------------
module mem_wb_stage #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              latchn,
    input  logic [DATA_W-1:0] aluResult_i,
    input  logic              baluResult_i,
    input  logic [ADDR_W-1:0] target_i,
    input  logic [4:0]        rd_i,
    input  logic              isBtype_i,
    input  logic              isItype_i,
    input  logic              isRtype_i,
    input  logic              isStype_i,
    input  logic              isJtype_i,
    input  logic              probablyHalt_i,
    input  logic [6:0]        opcode_i,
    input  logic [DATA_W-1:0] memWriteValue_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              bpr_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] D_MEM_DI,
    output logic              D_MEM_CSN,
    output logic              D_MEM_WEN,
    output logic [3:0]        D_MEM_BE,
    output logic [ADDR_W-1:0] D_MEM_ADDR,
    output logic [DATA_W-1:0] D_MEM_DOUT,
    output logic              redirect_o,
    output logic [ADDR_W-1:0] redirectPc_o,
    output logic [DATA_W-1:0] wbData_o,
    output logic [4:0]        wbRd_o,
    output logic              wbWe_o,
    output logic              halt_o,
    output logic [31:0]       retired_o,
    output logic [1:0]        dbg_state
);

    localparam logic [6:0] OPC_LOAD = 7'b0000011;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic              valid;
    logic              is_load;
    logic              is_store;
    logic              enable;
    logic [ADDR_W-1:0] pc_plus4;
    logic              wb_we_d;
    logic [DATA_W-1:0] wb_data_d;

    // ------------------------------------------------------------------
    // Qualification
    // ------------------------------------------------------------------
    assign valid    = ~flush_i & (state_q != ST_HALTED);
    assign is_load  = valid & (opcode_i == OPC_LOAD);
    assign is_store = valid & isStype_i;
    assign enable   = ~latchn;

    // Natural ADDR_W-bit addition wraps the fall-through pc at the top of
    // the address space.
    assign pc_plus4 = pc_i + ADDR_W'(4);

    // ------------------------------------------------------------------
    // Data memory
    // ------------------------------------------------------------------
    assign D_MEM_CSN  = ~(is_load | is_store);
    assign D_MEM_WEN  = ~(is_store & enable);
    assign D_MEM_BE   = 4'b1111;
    assign D_MEM_ADDR = aluResult_i[ADDR_W-1:0];
    assign D_MEM_DOUT = memWriteValue_i;

    // ------------------------------------------------------------------
    // Branch / jump resolution
    // A branch redirects only when the fetch prediction was wrong; the
    // redirect target is whichever path fetch did not take. A jump is
    // always taken, so it redirects only when fetch predicted not-taken.
    // ------------------------------------------------------------------
    always_comb begin
        redirect_o   = 1'b0;
        redirectPc_o = '0;
        if (valid && enable) begin
            if (isBtype_i) begin
                if (baluResult_i ^ bpr_i) begin
                    redirect_o   = 1'b1;
                    redirectPc_o = baluResult_i ? target_i : pc_plus4;
                end
            end else if (isJtype_i) begin
                if (!bpr_i) begin
                    redirect_o   = 1'b1;
                    redirectPc_o = target_i;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Halt FSM
    // DRAIN exists so the halt instruction itself completes writeback
    // before the core stops; the next enabled cycle enters HALTED.
    // A redirect in the same cycle wins over a halt candidate.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (valid && probablyHalt_i && enable && !redirect_o) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (enable) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign halt_o    = (state_q == ST_HALTED);
    assign dbg_state = state_q;

    // ------------------------------------------------------------------
    // MEM/WB latch
    // Loads are I-type, so they are covered by the I-type write enable.
    // Jumps write the link address (pc+4, zero-extended).
    // ------------------------------------------------------------------
    assign wb_we_d = valid & (isRtype_i | isItype_i | isJtype_i) & (rd_i != 5'd0);

    always_comb begin
        wb_data_d = aluResult_i;
        if (is_load) begin
            wb_data_d = D_MEM_DI;
        end else if (isJtype_i) begin
            wb_data_d = {{(DATA_W-ADDR_W){1'b0}}, pc_plus4};
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            wbData_o <= '0;
            wbRd_o   <= '0;
            wbWe_o   <= 1'b0;
        end else if (enable) begin
            wbData_o <= wb_data_d;
            wbRd_o   <= rd_i;
            wbWe_o   <= wb_we_d;
        end
    end

    // ------------------------------------------------------------------
    // Retired instruction counter
    // ------------------------------------------------------------------
`ifdef MEM_WB_RETIRE_COUNT_EN
    logic [31:0] retired_q;

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            retired_q <= '0;
        end else if (enable && valid) begin
            retired_q <= retired_q + 32'd1;
        end
    end

    assign retired_o = retired_q;
`else
    assign retired_o = 32'd0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_wb_stage
//
// Bench for mem_wb_stage. A behavioural model tracks the expected MEM/WB
// contents, retire count and halt progress; a compare process checks every
// output against it each cycle. Directed cases with literal expectations
// pin the model, then randomized traffic runs over several reset rounds.
// ---------------------------------------------------------------------------
module tb_mem_wb_stage;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int AMOD   = 1 << ADDR_W;

    // ------------------------------------------------------------------
    // DUT signals
    // ------------------------------------------------------------------
    logic              CLK = 1'b0;
    logic              RSTn;
    logic              latchn;
    logic [DATA_W-1:0] aluResult_i;
    logic              baluResult_i;
    logic [ADDR_W-1:0] target_i;
    logic [4:0]        rd_i;
    logic              isBtype_i, isItype_i, isRtype_i, isStype_i, isJtype_i;
    logic              probablyHalt_i;
    logic [6:0]        opcode_i;
    logic [DATA_W-1:0] memWriteValue_i;
    logic [ADDR_W-1:0] pc_i;
    logic              bpr_i;
    logic              flush_i;
    logic [DATA_W-1:0] D_MEM_DI;
    logic              D_MEM_CSN;
    logic              D_MEM_WEN;
    logic [3:0]        D_MEM_BE;
    logic [ADDR_W-1:0] D_MEM_ADDR;
    logic [DATA_W-1:0] D_MEM_DOUT;
    logic              redirect_o;
    logic [ADDR_W-1:0] redirectPc_o;
    logic [DATA_W-1:0] wbData_o;
    logic [4:0]        wbRd_o;
    logic              wbWe_o;
    logic              halt_o;
    logic [31:0]       retired_o;
    logic [1:0]        dbg_state;

    mem_wb_stage #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .CLK(CLK), .RSTn(RSTn), .latchn(latchn),
        .aluResult_i(aluResult_i), .baluResult_i(baluResult_i),
        .target_i(target_i), .rd_i(rd_i),
        .isBtype_i(isBtype_i), .isItype_i(isItype_i), .isRtype_i(isRtype_i),
        .isStype_i(isStype_i), .isJtype_i(isJtype_i),
        .probablyHalt_i(probablyHalt_i), .opcode_i(opcode_i),
        .memWriteValue_i(memWriteValue_i), .pc_i(pc_i), .bpr_i(bpr_i),
        .flush_i(flush_i), .D_MEM_DI(D_MEM_DI),
        .D_MEM_CSN(D_MEM_CSN), .D_MEM_WEN(D_MEM_WEN), .D_MEM_BE(D_MEM_BE),
        .D_MEM_ADDR(D_MEM_ADDR), .D_MEM_DOUT(D_MEM_DOUT),
        .redirect_o(redirect_o), .redirectPc_o(redirectPc_o),
        .wbData_o(wbData_o), .wbRd_o(wbRd_o), .wbWe_o(wbWe_o),
        .halt_o(halt_o), .retired_o(retired_o), .dbg_state(dbg_state)
    );

    // ------------------------------------------------------------------
    // Clock
    // ------------------------------------------------------------------
    always #5 CLK = ~CLK;

    // ------------------------------------------------------------------
    // Scoreboard counters
    // ------------------------------------------------------------------
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // m_halt_seen: a halt instruction was accepted, core stops after one
    // more enabled cycle. m_halted: core is stopped until reset.
    // ------------------------------------------------------------------
    bit          model_ok = 0;
    bit          m_halt_seen;
    bit          m_halted;
    logic [31:0] m_wb_data;
    logic [4:0]  m_wb_rd;
    bit          m_wb_we;
    int unsigned m_retired;

    function automatic bit m_valid();
        return !flush_i && !m_halted;
    endfunction

    function automatic int m_pc4();
        return (int'(pc_i) + 4) % AMOD;
    endfunction

    function automatic void m_redirect(output bit r, output int p);
        r = 0;
        p = 0;
        if (m_valid() && !latchn) begin
            if (isBtype_i && (baluResult_i != bpr_i)) begin
                r = 1;
                p = baluResult_i ? int'(target_i) : m_pc4();
            end else if (!isBtype_i && isJtype_i && !bpr_i) begin
                r = 1;
                p = int'(target_i);
            end
        end
    endfunction

    always @(posedge CLK) begin
        bit r;
        int p;
        bit v;
        if (!RSTn) begin
            model_ok    = 1;
            m_halt_seen = 0;
            m_halted    = 0;
            m_wb_data   = 0;
            m_wb_rd     = 0;
            m_wb_we     = 0;
            m_retired   = 0;
        end else if (model_ok && !latchn) begin
            v = m_valid();
            m_redirect(r, p);
            m_wb_rd = rd_i;
            m_wb_we = v && (isRtype_i || isItype_i || isJtype_i) && rd_i != 0;
            if (v && opcode_i == 7'd3)
                m_wb_data = D_MEM_DI;
            else if (isJtype_i)
                m_wb_data = 32'(m_pc4());
            else
                m_wb_data = aluResult_i;
            if (v) m_retired = m_retired + 1;
            if (m_halt_seen) begin
                m_halted    = 1;
                m_halt_seen = 0;
            end else if (v && probablyHalt_i && !r) begin
                m_halt_seen = 1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Compare process: every cycle, 2 time units after inputs change
    // ------------------------------------------------------------------
    always @(negedge CLK) begin
        bit r;
        int p;
        bit v;
        bit ld, st;
        #2;
        if (model_ok) begin
            v  = m_valid();
            ld = v && opcode_i == 7'd3;
            st = v && isStype_i;
            m_redirect(r, p);
            chk("csn",        D_MEM_CSN, !(ld || st));
            chk("wen",        D_MEM_WEN, !(st && !latchn));
            chk("be",         D_MEM_BE, 4'hF);
            chk("addr",       D_MEM_ADDR, aluResult_i % AMOD);
            chk("dout",       D_MEM_DOUT, memWriteValue_i);
            chk("redirect",   redirect_o, r);
            chk("redirectpc", redirectPc_o, p);
            chk("wbdata",     wbData_o, m_wb_data);
            chk("wbrd",       wbRd_o, m_wb_rd);
            chk("wbwe",       wbWe_o, m_wb_we);
            chk("halt",       halt_o, m_halted);
`ifdef MEM_WB_RETIRE_COUNT_EN
            chk("retired",    retired_o, m_retired);
`else
            chk("retired",    retired_o, 0);
`endif
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks (inputs change just after negedge)
    // ------------------------------------------------------------------
    task automatic clear_inputs();
        latchn = 0; aluResult_i = 0; baluResult_i = 0; target_i = 0; rd_i = 0;
        isBtype_i = 0; isItype_i = 0; isRtype_i = 0; isStype_i = 0; isJtype_i = 0;
        probablyHalt_i = 0; opcode_i = 7'h13; memWriteValue_i = 0; pc_i = 0;
        bpr_i = 0; flush_i = 0; D_MEM_DI = 0;
    endtask

    task automatic next_cycle();
        @(negedge CLK);
        clear_inputs();
    endtask

    task automatic rand_inputs();
        int kind;
        clear_inputs();
        flush_i         = ($urandom_range(0, 4) == 0);
        latchn          = ($urandom_range(0, 5) == 0);
        aluResult_i     = $urandom;
        memWriteValue_i = $urandom;
        D_MEM_DI        = $urandom;
        target_i        = ADDR_W'($urandom);
        pc_i            = ($urandom_range(0, 9) == 0) ? 12'hFFC : ADDR_W'($urandom & 32'hFFC);
        rd_i            = 5'($urandom_range(0, 31));
        baluResult_i    = 1'($urandom);
        bpr_i           = 1'($urandom);
        probablyHalt_i  = ($urandom_range(0, 40) == 0);
        opcode_i        = 7'($urandom);
        if (opcode_i == 7'd3) opcode_i = 7'h33;
        kind = $urandom_range(0, 6);
        case (kind)
            1: isRtype_i = 1;
            2: isItype_i = 1;
            3: begin isItype_i = 1; opcode_i = 7'd3; end
            4: isStype_i = 1;
            5: isBtype_i = 1;
            6: isJtype_i = 1;
            default: ;
        endcase
    endtask

    task automatic do_reset();
        @(negedge CLK);
        rand_inputs();
        RSTn    = 0;
        flush_i = 1;
        repeat (3) begin
            @(negedge CLK);
            rand_inputs();
            flush_i = 1;
        end
        RSTn = 1;
        clear_inputs();
        flush_i = 1;
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        logic [31:0] held_data;
        logic [31:0] held_ret;
        RSTn = 0;
        clear_inputs();
        flush_i = 1;
        do_reset();

        // Reset state
        @(negedge CLK);
        clear_inputs();
        flush_i = 1;
        #3;
        chk("rst_wbdata", wbData_o, 0);
        chk("rst_wbrd", wbRd_o, 0);
        chk("rst_wbwe", wbWe_o, 0);
        chk("rst_halt", halt_o, 0);
        chk("rst_retired", retired_o, 0);

        // Load x5 from 0x010
        next_cycle();
        isItype_i = 1; opcode_i = 7'd3; rd_i = 5; aluResult_i = 32'h010;
        D_MEM_DI = 32'hDEADBEEF;
        #3;
        chk("ld_csn", D_MEM_CSN, 0);
        chk("ld_wen", D_MEM_WEN, 1);
        chk("ld_addr", D_MEM_ADDR, 12'h010);

        // Store 0x12345678 to 0x020 (also observes the load writeback)
        next_cycle();
        #3;
        chk("ld_wbdata", wbData_o, 32'hDEADBEEF);
        chk("ld_wbrd", wbRd_o, 5);
        chk("ld_wbwe", wbWe_o, 1);
`ifdef MEM_WB_RETIRE_COUNT_EN
        chk("ld_retired", retired_o, 1);
`endif
        isStype_i = 1; opcode_i = 7'h23; aluResult_i = 32'h020;
        memWriteValue_i = 32'h12345678;
        #1;
        chk("st_csn", D_MEM_CSN, 0);
        chk("st_wen", D_MEM_WEN, 0);
        chk("st_be", D_MEM_BE, 4'hF);
        chk("st_addr", D_MEM_ADDR, 12'h020);
        chk("st_dout", D_MEM_DOUT, 32'h12345678);
        next_cycle();
        #3;
        chk("st_wbwe", wbWe_o, 0);

        // Branch cases
        isBtype_i = 1; pc_i = 12'h100; target_i = 12'h040; baluResult_i = 1; bpr_i = 0;
        #1;
        chk("br_taken_redir", redirect_o, 1);
        chk("br_taken_pc", redirectPc_o, 12'h040);
        baluResult_i = 0; bpr_i = 1;
        #1;
        chk("br_nt_pc", redirectPc_o, 12'h104);
        pc_i = 12'hFFC;
        #1;
        chk("br_wrap_pc", redirectPc_o, 12'h000);

        // Stall with store and with mispredicted branch
        next_cycle();
        #3;
        held_data = wbData_o;
        held_ret  = retired_o;
        latchn = 1; isStype_i = 1; aluResult_i = 32'h77;
        #1;
        chk("stall_wen", D_MEM_WEN, 1);
        next_cycle();
        latchn = 1; isBtype_i = 1; baluResult_i = 1; bpr_i = 0; target_i = 12'h123;
        aluResult_i = 32'h99;
        #3;
        chk("stall_redir", redirect_o, 0);
        chk("stall_wbdata", wbData_o, held_data);
        chk("stall_retired", retired_o, held_ret);

        // Flushed store / branch
        next_cycle();
        #3;
        held_ret = retired_o;
        flush_i = 1; isStype_i = 1; rd_i = 7;
        #1;
        chk("flush_csn", D_MEM_CSN, 1);
        next_cycle();
        flush_i = 1; isBtype_i = 1; baluResult_i = 1; bpr_i = 0; rd_i = 7;
        #3;
        chk("flush_redir", redirect_o, 0);
        next_cycle();
        #3;
        chk("flush_wbwe", wbWe_o, 0);
        chk("flush_retired", retired_o, held_ret);

        // Halt sequence
        probablyHalt_i = 1; opcode_i = 7'h73;
        next_cycle();
        #3;
        chk("halt_drain", halt_o, 0);
        next_cycle();
        #3;
        chk("halt_halted", halt_o, 1);
        isStype_i = 1;
        #1;
        chk("halt_csn", D_MEM_CSN, 1);
        chk("halt_wen", D_MEM_WEN, 1);

        // Randomized rounds
        for (int round = 0; round < 5; round++) begin
            do_reset();
            for (int c = 0; c < 300; c++) begin
                @(negedge CLK);
                rand_inputs();
            end
        end

        next_cycle();
        flush_i = 1;
        @(negedge CLK);
        #4;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
